layer_output_streamer: RTL and testbench
========================================

LAYER_OUTPUT_STREAMER -- requirements
Module: layer_output_streamer

Interface
REQ-001 SHALL have parameter numNeurons, default 30, number of neuron outputs per layer word (>=2).
REQ-002 SHALL have parameter dataWidth, default 16, width of one neuron output and of the streamed element.
REQ-003 SHALL have parameter minGap, default 8, number of idle cycles forced after each burst (>=1).
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port in_data  input  numNeurons*dataWidth  parallel layer outputs; neuron k in bits [k*dataWidth +: dataWidth].
REQ-007 SHALL have port in_valid  input  1  one-cycle strobe; in_data valid this cycle.
REQ-008 SHALL have port out_data  output  dataWidth  serial element to next layer's myinput.
REQ-009 SHALL have port out_valid  output  1  serial element valid; drives next layer's myinputValid.
REQ-010 SHALL have port busy  output  1  high in STREAM or GAP.
REQ-011 SHALL have port overflow  output  1  sticky; a layer word was dropped.

Function
REQ-012 SHALL implement states IDLE, STREAM, GAP, plus a one-deep pending buffer (data + pend_valid).
REQ-013 IDLE with in_valid=1: SHALL capture in_data into active buffer, element index=0, go to STREAM.
REQ-014 Latency: first out_valid SHALL occur in the cycle after in_valid is sampled (registered output).
REQ-015 STREAM: SHALL emit elements 0..numNeurons-1 in order, one per cycle, out_valid=1 on exactly numNeurons contiguous cycles, no bubbles.
REQ-016 After element numNeurons-1: SHALL enter GAP; out_valid=0 for exactly minGap cycles.
REQ-017 out_data SHALL be 0 whenever out_valid=0.
REQ-018 in_valid in STREAM or GAP with pend_valid=0: SHALL store in_data in pending buffer, set pend_valid.
REQ-019 in_valid in STREAM or GAP with pend_valid=1: SHALL drop new word, keep pending contents, set overflow.
REQ-020 End of GAP, pend_valid=1: SHALL load pending into active buffer, clear pend_valid, go to STREAM; if in_valid same cycle, that word SHALL go to pending (no overflow).
REQ-021 End of GAP, pend_valid=0, in_valid=1: SHALL load in_data directly, go to STREAM.
REQ-022 End of GAP, pend_valid=0, in_valid=0: SHALL go to IDLE.
REQ-023 Next burst's first out_valid SHALL follow the previous burst's last out_valid by exactly minGap+1 cycles when data is waiting.
REQ-024 busy SHALL be 1 in STREAM and GAP, 0 in IDLE; registered with state.
REQ-025 overflow SHALL stay 1 until rst; no other clear.
REQ-026 Element index counter SHALL be $clog2(numNeurons) bits wide; gap counter $clog2(minGap+1) bits wide; no wrap beyond terminal count.
REQ-027 Data SHALL pass unmodified (no sign change, no saturation).

Reset
REQ-028 rst=1 SHALL force, next edge: state IDLE, out_valid=0, out_data=0, busy=0, overflow=0, pend_valid=0, counters=0.
REQ-029 rst mid-STREAM or mid-GAP SHALL abort the burst; no further out_valid until a new in_valid after rst deasserts.
REQ-030 in_valid during rst SHALL be ignored.

Verification (numNeurons=4, dataWidth=16, minGap=3 unless stated)
REQ-031 Single word: in_data={16'h0004,16'h0003,16'h0002,16'h0001}, in_valid at cycle 0 -> out_valid cycles 1-4, out_data 0001,0002,0003,0004; busy 0 at cycle 8.
REQ-032 Back-to-back: second word (elements 0011..0014) at cycle 2 -> pending; its out_valid on cycles 8-11; overflow=0.
REQ-033 Overflow: third in_valid at cycle 3 with pending full -> dropped, overflow=1 from cycle 4, second word still streams intact.
REQ-034 Coincident load: in_valid at last GAP cycle with pend_valid=1 -> pending streams next, new word queued, streamed after following GAP; overflow=0.
REQ-035 Reset mid-stream: rst at cycle 2 -> out_valid=0, busy=0 from cycle 3; remaining elements never appear.
REQ-036 Default parameters: one word -> exactly 30 contiguous out_valid cycles, then 8 idle cycles before busy=0.

Source files
------------

// File: rtl/layer_output_streamer.sv
// -----------------------------------------------------------------------------
// layer_output_streamer
//
// Converts one parallel layer word (numNeurons outputs of dataWidth bits) into
// a serial stream of numNeurons elements, one per cycle, followed by a forced
// idle gap of minGap cycles. A one-deep pending buffer absorbs a word arriving
// while a burst or gap is in progress; further words are dropped and flagged.
//
// Ports
//   clk        : single clock, rising edge
//   rst        : synchronous, active-high reset
//   in_data    : parallel layer outputs, neuron k at [k*dataWidth +: dataWidth]
//   in_valid   : one-cycle strobe qualifying in_data
//   out_data   : serial element (0 whenever out_valid is low)
//   out_valid  : serial element valid
//   busy       : high while streaming or in the gap
//   overflow   : sticky flag, a layer word was dropped
// -----------------------------------------------------------------------------
module layer_output_streamer #(
  parameter int numNeurons = 30,
  parameter int dataWidth  = 16,
  parameter int minGap     = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [numNeurons*dataWidth-1:0]  in_data,
  input  logic                             in_valid,
  output logic [dataWidth-1:0]             out_data,
  output logic                             out_valid,
  output logic                             busy,
  output logic                             overflow
);

  localparam int WORD_W = numNeurons * dataWidth;
  localparam int IDX_W  = $clog2(numNeurons);
  localparam int GAP_W  = $clog2(minGap + 1);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(numNeurons - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(minGap - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    GAP    = 2'd2
  } state_e;

  // Control state
  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic               pend_valid_q, pend_valid_d;
  logic               ovf_q, ovf_d;

  // Data state (not reset; only ever observed through state-gated outputs)
  logic [WORD_W-1:0]  act_q, act_d;
  logic [WORD_W-1:0]  pend_q, pend_d;

  logic               gap_end;
  logic               queue_in;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    gap_d        = gap_q;
    pend_valid_d = pend_valid_q;
    ovf_d        = ovf_q;
    act_d        = act_q;
    pend_d       = pend_q;

    gap_end  = (state_q == GAP) && (gap_q == GAP_LAST);
    // A word arriving while busy, except on the gap's last cycle where it is
    // handled together with the reload decision below.
    queue_in = in_valid && ((state_q == STREAM) || ((state_q == GAP) && !gap_end));

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          act_d   = in_data;
          idx_d   = '0;
          state_d = STREAM;
        end
      end

      STREAM: begin
        // Active buffer shifts down so the current element is always in the
        // low slice.
        act_d = act_q >> dataWidth;
        if (idx_q == IDX_LAST) begin
          idx_d   = '0;
          gap_d   = '0;
          state_d = GAP;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      GAP: begin
        if (gap_end) begin
          gap_d = '0;
          idx_d = '0;
          if (pend_valid_q) begin
            act_d        = pend_q;
            pend_valid_d = 1'b0;
            state_d      = STREAM;
            // The pending slot frees up this same cycle, so a coincident
            // word takes it without overflow.
            if (in_valid) begin
              pend_d       = in_data;
              pend_valid_d = 1'b1;
            end
          end else if (in_valid) begin
            act_d   = in_data;
            state_d = STREAM;
          end else begin
            state_d = IDLE;
          end
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (queue_in) begin
      if (pend_valid_q) begin
        ovf_d = 1'b1;
      end else begin
        pend_d       = in_data;
        pend_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      gap_q        <= '0;
      pend_valid_q <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      gap_q        <= gap_d;
      pend_valid_q <= pend_valid_d;
      ovf_q        <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    act_q  <= act_d;
    pend_q <= pend_d;
  end

  // Outputs depend only on registered state
  assign out_valid = (state_q == STREAM);
  assign out_data  = out_valid ? act_q[dataWidth-1:0] : '0;
  assign busy      = (state_q != IDLE);
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_layer_output_streamer.sv
module tb_layer_output_streamer;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int G  = 3;
  localparam int WW = N * DW;

  localparam int N2  = 30;
  localparam int G2  = 8;
  localparam int WW2 = N2 * DW;

  logic           clk = 1'b0;
  logic           rst;
  logic [WW-1:0]  in_data;
  logic           in_valid;
  logic [DW-1:0]  out_data;
  logic           out_valid;
  logic           busy;
  logic           overflow;

  logic [WW2-1:0] in_data2;
  logic           in_valid2;
  logic [DW-1:0]  out_data2;
  logic           out_valid2;
  logic           busy2;
  logic           overflow2;

  always #5 clk = ~clk;

  layer_output_streamer #(.numNeurons(N), .dataWidth(DW), .minGap(G)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .out_data  (out_data),
    .out_valid (out_valid),
    .busy      (busy),
    .overflow  (overflow)
  );

  layer_output_streamer dut2 (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data2),
    .in_valid  (in_valid2),
    .out_data  (out_data2),
    .out_valid (out_valid2),
    .busy      (busy2),
    .overflow  (overflow2)
  );

  int n_vec = 0;
  int n_mis = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard of expected serial elements for dut
  logic [DW-1:0] sb[$];
  bit            mon_en = 1'b0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (out_valid === 1'b1) begin
        if (sb.size() == 0) begin
          chk("sb_extra", 64'(sb.size()), 64'd1);
        end else begin
          chk("sb_data", out_data, sb.pop_front());
        end
      end else begin
        chk("idle_zero", out_data, '0);
      end
    end
  end

  // Per-cycle stimulus table for one scenario
  localparam int MAXC = 32;
  logic [WW-1:0] st_word [MAXC];
  bit            st_v    [MAXC];
  bit            st_rst  [MAXC];
  int            st_push [MAXC];
  logic [31:0]   ov_h, bz_h, of_h;

  task automatic clr_stim();
    for (int c = 0; c < MAXC; c++) begin
      st_word[c] = '0;
      st_v[c]    = 1'b0;
      st_rst[c]  = 1'b0;
      st_push[c] = 0;
    end
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_valid2 = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst    = 1'b0;
    mon_en = 1'b1;
    chk("rst_valid",    out_valid, 1'b0);
    chk("rst_busy",     busy,      1'b0);
    chk("rst_overflow", overflow,  1'b0);
    chk("rst_data",     out_data,  '0);
  endtask

  // Cycle c starts just after a rising edge; outputs are recorded, then the
  // inputs for cycle c are driven and sampled by the next edge.
  task automatic run(input int len);
    logic [WW-1:0] w;
    ov_h = '0;
    bz_h = '0;
    of_h = '0;
    for (int c = 0; c < len; c++) begin
      ov_h[c]  = out_valid;
      bz_h[c]  = busy;
      of_h[c]  = overflow;
      w        = st_word[c];
      rst      = st_rst[c];
      in_valid = st_v[c];
      in_data  = w;
      for (int k = 0; k < st_push[c]; k++) sb.push_back(w[k*DW +: DW]);
      @(posedge clk);
      #1;
    end
    rst      = 1'b0;
    in_valid = 1'b0;
    chk("sb_drain", 64'(sb.size()), 64'd0);
  endtask

  logic [WW-1:0] w1, w2, w3;

  initial begin
    int first2, last2, cnt2, badz2;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_valid2 = 1'b0;
    in_data2  = '0;
    w1 = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
    w2 = {16'h0014, 16'h0013, 16'h0012, 16'h0011};
    w3 = {16'h8024, 16'hFF23, 16'h0022, 16'h7F21};

    // Single word: valid on 1-4, busy through the 3-cycle gap, idle at 8
    do_reset();
    clr_stim();
    st_v[0] = 1; st_word[0] = w1; st_push[0] = 4;
    run(10);
    chk("s1_ov",   ov_h, 32'h0000_001E);
    chk("s1_busy", bz_h, 32'h0000_00FE);
    chk("s1_ovf",  of_h, 32'h0);

    // Back-to-back: second word pends, streams 8-11
    do_reset();
    clr_stim();
    st_v[0] = 1; st_word[0] = w1; st_push[0] = 4;
    st_v[2] = 1; st_word[2] = w2; st_push[2] = 4;
    run(14);
    chk("s2_ov",   ov_h, 32'h0000_0F1E);
    chk("s2_busy", bz_h, 32'h0000_3FFE);
    chk("s2_ovf",  of_h, 32'h0);

    // Overflow: third word dropped, flag from cycle 4, sticky
    do_reset();
    clr_stim();
    st_v[0] = 1; st_word[0] = w1; st_push[0] = 4;
    st_v[2] = 1; st_word[2] = w2; st_push[2] = 4;
    st_v[3] = 1; st_word[3] = w3; st_push[3] = 0;
    run(14);
    chk("s3_ov",   ov_h, 32'h0000_0F1E);
    chk("s3_busy", bz_h, 32'h0000_3FFE);
    chk("s3_ovf",  of_h, 32'h0000_3FF0);

    // Coincident load on the last gap cycle with pending full
    do_reset();
    clr_stim();
    st_v[0] = 1; st_word[0] = w1; st_push[0] = 4;
    st_v[2] = 1; st_word[2] = w2; st_push[2] = 4;
    st_v[7] = 1; st_word[7] = w3; st_push[7] = 4;
    run(24);
    chk("s4_ov",   ov_h, 32'h0007_8F1E);
    chk("s4_busy", bz_h, 32'h003F_FFFE);
    chk("s4_ovf",  of_h, 32'h0);

    // Direct load at gap end with nothing pending
    do_reset();
    clr_stim();
    st_v[0] = 1; st_word[0] = w1; st_push[0] = 4;
    st_v[7] = 1; st_word[7] = w3; st_push[7] = 4;
    run(14);
    chk("s5_ov",   ov_h, 32'h0000_0F1E);
    chk("s5_busy", bz_h, 32'h0000_3FFE);
    chk("s5_ovf",  of_h, 32'h0);

    // Reset mid-stream aborts; in_valid during reset ignored
    do_reset();
    clr_stim();
    st_v[0] = 1; st_word[0] = w1; st_push[0] = 2;
    st_rst[2] = 1;
    st_rst[3] = 1; st_v[3] = 1; st_word[3] = w2;
    run(12);
    chk("s6_ov",   ov_h, 32'h0000_0006);
    chk("s6_busy", bz_h, 32'h0000_0006);
    chk("s6_ovf",  of_h, 32'h0);

    // Default parameters: 30 contiguous elements then 8 idle cycles
    do_reset();
    for (int k = 0; k < N2; k++) in_data2[k*DW +: DW] = 16'(16'h0100 + k);
    in_valid2 = 1'b1;
    @(posedge clk);
    #1;
    in_valid2 = 1'b0;
    first2 = -1; last2 = -1; cnt2 = 0; badz2 = 0;
    for (int c = 1; c < 45; c++) begin
      if (out_valid2) begin
        if (first2 < 0) first2 = c;
        last2 = c;
        chk("d_data", out_data2, 16'(16'h0100 + cnt2));
        cnt2++;
      end else if (out_data2 != '0) begin
        badz2++;
      end
      if (c == N2 + G2) chk("d_busy_last_gap", busy2, 1'b1);
      if (c == N2 + G2 + 1) chk("d_busy_idle", busy2, 1'b0);
      @(posedge clk);
      #1;
    end
    chk("d_count", 64'(cnt2),   64'd30);
    chk("d_first", 64'(first2), 64'd1);
    chk("d_last",  64'(last2),  64'd30);
    chk("d_zero",  64'(badz2),  64'd0);
    chk("d_ovf",   overflow2,   1'b0);

    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
